mod_mult_interleaved: RTL and testbench
=======================================

Name: mod_mult_interleaved

Overview:
Parametrised modular multiplier computing product = (a * b) mod n using MSB-first interleaved shift-add-reduce (Blakley): one multiplier bit per clock, with fully bounded reduction in each iteration. It replaces fixed-width, fixed-modulus multipliers in the point-arithmetic and signing datapaths. The modulus is a runtime port, so one instance serves both the field prime p and the group order n. A start/busy/done handshake lets the curve controller issue back-to-back operations.

Parameters:
WIDTH, 256, operand/modulus bit width; legal range ≥ 2.
CNT_W, $clog2(WIDTH), iteration counter width; derived, do not override.

Ports:
clk        input   1      clock
Reset      input   1      synchronous, active-high reset
start      input   1      request; sampled only in IDLE
a          input   WIDTH  multiplicand, captured on accepted start
b          input   WIDTH  multiplier, captured on accepted start
modulus    input   WIDTH  n, captured on accepted start
busy       output  1      high from the cycle after start is accepted until done is asserted
done       output  1      one-cycle pulse; product is valid
product    output  WIDTH  result register; holds value until the next accepted start
err        output  1      range-check failure flag (see Optional Feature); valid with done

Behaviour:
- Reset, and clk is the only clock.
- Reset is synchronous and active-high. After Reset: state = IDLE, busy = 0, done = 0, err = 0, product = 0, internal accumulator = 0, counter = 0.
- Reset asserted mid-operation aborts the operation immediately. The next cycle is IDLE with all outputs at their reset values.
- FSM states are IDLE, RUN and FIN.
- IDLE:
  - When start = 1, latch a, b and modulus into internal registers.
  - Clear the accumulator c (WIDTH+2 bits).
  - Set counter = WIDTH-1.
  - Go to RUN.
- RUN, one iteration per cycle, processing bit i = counter of the latched a (MSB first):
  - t = 2c + (a[i] ? b : 0), computed in WIDTH+2 bits.
  - If t ≥ 2n: c ← t − 2n. Else if t ≥ n: c ← t − n. Else: c ← t.
  - All comparisons and subtractions are zero-extended to WIDTH+2 bits.
  - Invariant: c < n after every iteration, provided a < n and b < n.
  - When counter = 0, go to FIN after this iteration; otherwise decrement counter.
- FIN:
  - product ← c[WIDTH-1:0].
  - done = 1 for exactly this cycle.
  - busy = 0.
  - Return to IDLE.
- Latency: start sampled high at edge k → done high in cycle k+WIDTH+1. A new start is accepted at the earliest in the cycle after FIN.
- busy = 1 in RUN only.
- start while busy (or in FIN) is ignored. Inputs may change freely after acceptance.
- Boundaries:
  - a = 0 or b = 0 → product 0.
  - n = 1 → product 0.
  - a, b = n−1 → product 1.
  - Out-of-range operands (a ≥ n or b ≥ n) or n = 0 without the check: the result is deterministic but unspecified, and err = 0.
- done and err are registered outputs; no combinational path exists from inputs to outputs.

Optional Feature:
Macro: MOD_MULT_RANGE_CHECK_EN.
- Defined:
  - In IDLE on an accepted start, the block compares a ≥ modulus, b ≥ modulus and modulus < 2.
  - If any comparison is true, the block skips RUN and goes directly to FIN on the next cycle.
  - FIN then asserts done = 1 and err = 1, and sets product = 0.
  - Latency in the error case is 2 cycles.
  - Otherwise err = 0 and behaviour is as above.
  - err holds until the next accepted start or Reset.
- Undefined: the range comparators are not built, and err is tied to 0.

Test Plan:
1. WIDTH=8; a=5, b=7, modulus=11; start pulse → busy for 8 cycles, then done at cycle 9, product=2, err=0.
2. WIDTH=256; modulus=2^256−189, a=2^255, b=2 → product=189 after 257 cycles. Also a=b=modulus−1 → product=1. Also a=0 → product=0.
3. WIDTH=8; start (a=10, b=10, modulus=13) and hold start high for 4 more cycles, changing a to 3 → single done, product=9. The repeated start is ignored. A start issued in the cycle after FIN is accepted.
4. WIDTH=8; start (a=5, b=7, modulus=11), assert Reset at cycle 4 of RUN → next cycle busy=0, done=0, product=0. A new start (a=3, b=4, modulus=5) → product=2 with the full 9-cycle latency.
5. WIDTH=8, MOD_MULT_RANGE_CHECK_EN defined; a=12, b=3, modulus=11 → done 2 cycles after start, err=1, product=0. Then a=3, b=4, modulus=11 → product=1, err=0.
6. WIDTH=8, macro undefined; randomized 1000 operations with modulus ≥ 2 and a, b < modulus → every product matches the reference (a*b)%modulus, and every done arrives exactly WIDTH+1 cycles after its start.

Source files
------------

// File: rtl/mod_mult_interleaved_if.sv
// rtl/mod_mult_interleaved_if.sv - start/busy/done handshake bundle for the interleaved modular multiplier
interface mod_mult_interleaved_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             err;

    modport master (
        output start, a, b, modulus,
        input  busy, done, product, err
    );

    modport slave (
        input  start, a, b, modulus,
        output busy, done, product, err
    );
endinterface

// File: rtl/mod_mult_interleaved.sv
// rtl/mod_mult_interleaved.sv - MSB-first interleaved (Blakley) modular multiplier, one multiplier bit per clock
// Optional operand range check is built when MOD_MULT_RANGE_CHECK_EN is defined.
module mod_mult_interleaved #(
    parameter int WIDTH = 256,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 Reset,
    mod_mult_interleaved_if.slave mm
);
    localparam int CW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] product_q;
    logic [CW-1:0]    c_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [CW-1:0]    t;
    logic [CW-1:0]    c_next;
    logic [CW-1:0]    n_ext;
    logic [CW-1:0]    n2_ext;

    // Accumulator stays below n, so 2c + b fits in WIDTH+2 bits and one
    // subtraction of either n or 2n restores c < n.
    always_comb begin
        n_ext  = {2'b00, n_q};
        n2_ext = {1'b0, n_q, 1'b0};
        t      = {c_q[CW-2:0], 1'b0} + (a_q[cnt_q] ? {2'b00, b_q} : {CW{1'b0}});
        if (t >= n2_ext) begin
            c_next = t - n2_ext;
        end else if (t >= n_ext) begin
            c_next = t - n_ext;
        end else begin
            c_next = t;
        end
    end

`ifdef MOD_MULT_RANGE_CHECK_EN
    logic bad_q;
    logic err_q;
    logic range_bad;

    assign range_bad = (mm.a >= mm.modulus) || (mm.b >= mm.modulus) ||
                       (mm.modulus < WIDTH'(2));
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            n_q       <= '0;
            product_q <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MOD_MULT_RANGE_CHECK_EN
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mm.start) begin
                        a_q    <= mm.a;
                        b_q    <= mm.b;
                        n_q    <= mm.modulus;
                        c_q    <= '0;
                        cnt_q  <= CNT_W'(WIDTH - 1);
                        busy_q <= 1'b1;
                        state  <= RUN;
`ifdef MOD_MULT_RANGE_CHECK_EN
                        bad_q  <= range_bad;
                        err_q  <= 1'b0;
`endif
                    end
                end
                RUN: begin
`ifdef MOD_MULT_RANGE_CHECK_EN
                    // A rejected operand set spends a single cycle here and
                    // leaves with a zero product instead of iterating.
                    if (bad_q) begin
                        state     <= FIN;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        product_q <= '0;
                    end else
`endif
                    begin
                        c_q <= c_next;
                        if (cnt_q == '0) begin
                            state     <= FIN;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            product_q <= c_next[WIDTH-1:0];
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mm.busy    = busy_q;
    assign mm.done    = done_q;
    assign mm.product = product_q;
`ifdef MOD_MULT_RANGE_CHECK_EN
    assign mm.err     = err_q;
`else
    assign mm.err     = 1'b0;
`endif
endmodule

// File: tb/tb_mod_mult_interleaved.sv
// tb/tb_mod_mult_interleaved.sv - self-checking bench for mod_mult_interleaved at WIDTH 8 and 256
module tb_mod_mult_interleaved;
    localparam int W  = 8;
    localparam int WB = 256;

    logic clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    mod_mult_interleaved_if #(.WIDTH(W))  if8 ();
    mod_mult_interleaved_if #(.WIDTH(WB)) if256 ();

    mod_mult_interleaved #(.WIDTH(W))  dut8   (.clk(clk), .Reset(Reset), .mm(if8.slave));
    mod_mult_interleaved #(.WIDTH(WB)) dut256 (.clk(clk), .Reset(Reset), .mm(if256.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic bit bad8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
`ifdef MOD_MULT_RANGE_CHECK_EN
        return (a >= n) || (b >= n) || (n < 8'd2);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: an accepted op occupies the block until its done
    // cycle (WIDTH cycles after acceptance, or 1 for a rejected op); the
    // result is plain (a*b) mod n.
    int         cyc = 0;
    int         m_done = 0;
    bit         m_live = 0, m_active = 0, m_bad = 0;
    bit         m_err = 0, m_next_err = 0, m_known = 0, m_next_known = 0;
    logic [7:0] m_prod = 0, m_next_prod = 0;

    always @(posedge clk) begin
        cyc++;
        if (Reset) begin
            m_live   = 1;
            m_active = 0;
            m_prod   = 0;
            m_err    = 0;
            m_known  = 1;
        end else if (!m_active) begin
            if (if8.start) begin
                m_bad      = bad8(if8.a, if8.b, if8.modulus);
                m_active   = 1;
                m_done     = cyc + (m_bad ? 1 : W);
                m_err      = 0;
                m_next_err = m_bad;
                if (m_bad) begin
                    m_next_prod  = 0;
                    m_next_known = 1;
                end else if (if8.modulus != 0 && if8.a < if8.modulus && if8.b < if8.modulus) begin
                    m_next_prod  = 8'((int'(if8.a) * int'(if8.b)) % int'(if8.modulus));
                    m_next_known = 1;
                end else begin
                    m_next_known = 0;
                end
            end
        end else if (cyc == m_done + 1) begin
            m_active = 0;
        end
        if (!Reset && m_active && cyc == m_done) begin
            m_prod  = m_next_prod;
            m_known = m_next_known;
            m_err   = m_next_err;
        end
        #1;
        if (m_live) begin
            chk("model_busy", if8.busy, m_active && cyc < m_done);
            chk("model_done", if8.done, m_active && cyc == m_done);
            chk("model_err",  if8.err,  m_err);
            if (m_known) chk("model_product", if8.product, m_prod);
        end
    end

    // Drive one op; start stays high for `hold` extra cycles with a corrupted a.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                       input int hold, output int lat);
        @(negedge clk);
        if8.start   = 1'b1;
        if8.a       = a;
        if8.b       = b;
        if8.modulus = n;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat > hold) begin
                if8.start   = 1'b0;
                if8.a       = 8'($urandom);
                if8.b       = 8'($urandom);
                if8.modulus = 8'($urandom);
            end else begin
                if8.a = 8'd3;
            end
        end while (!if8.done && lat < 400);
        if (!if8.done) chk("done_timeout8", if8.done, 1'b1);
    endtask

    task automatic op256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] n,
                         output int lat);
        @(negedge clk);
        if256.start   = 1'b1;
        if256.a       = a;
        if256.b       = b;
        if256.modulus = n;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if256.start = 1'b0;
            if256.a     = '1;
        end while (!if256.done && lat < 600);
        if (!if256.done) chk("done_timeout256", if256.done, 1'b1);
    endtask

    initial begin
        int         lat;
        int         exp_lat;
        bit         bad;
        logic [7:0] ra, rb, rn;
        logic [255:0] n256, a256;

        if8.start = 0;   if8.a = 0;   if8.b = 0;   if8.modulus = 0;
        if256.start = 0; if256.a = 0; if256.b = 0; if256.modulus = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    if8.busy, 0);
        chk("rst_done",    if8.done, 0);
        chk("rst_product", if8.product, 0);
        chk("rst_err",     if8.err, 0);
        chk("rst_busy256", if256.busy, 0);
        chk("rst_prod256", if256.product, 0);
        Reset = 1'b0;

        op8(8'd5, 8'd7, 8'd11, 0, lat);
        chk("t1_latency", lat, 9);
        chk("t1_product", if8.product, 8'd2);
        chk("t1_err",     if8.err, 0);

        op8(8'd0,   8'd200, 8'd251, 0, lat); chk("a_zero",  if8.product, 8'd0);
        op8(8'd123, 8'd0,   8'd251, 0, lat); chk("b_zero",  if8.product, 8'd0);
        op8(8'd0,   8'd0,   8'd1,   0, lat); chk("n_one",   if8.product, 8'd0);
        op8(8'd250, 8'd250, 8'd251, 0, lat); chk("nm1_251", if8.product, 8'd1);
        op8(8'd254, 8'd254, 8'd255, 0, lat); chk("nm1_255", if8.product, 8'd1);
        op8(8'd1,   8'd1,   8'd2,   0, lat); chk("nm1_2",   if8.product, 8'd1);

        op8(8'd10, 8'd10, 8'd13, 4, lat);
        chk("t3_latency", lat, 9);
        chk("t3_product", if8.product, 8'd9);
        op8(8'd5, 8'd7, 8'd11, 0, lat);
        chk("b2b_latency", lat, 9);
        chk("b2b_product", if8.product, 8'd2);

        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd5; if8.b = 8'd7; if8.modulus = 8'd11;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        chk("t4_busy",    if8.busy, 0);
        chk("t4_done",    if8.done, 0);
        chk("t4_product", if8.product, 0);
        Reset = 1'b0;
        op8(8'd3, 8'd4, 8'd5, 0, lat);
        chk("t4_latency", lat, 9);
        chk("t4_product2", if8.product, 8'd2);

        bad = bad8(8'd12, 8'd3, 8'd11);
        op8(8'd12, 8'd3, 8'd11, 0, lat);
        chk("t5_latency", lat, bad ? 2 : 9);
        chk("t5_err", if8.err, bad);
        if (bad) chk("t5_product", if8.product, 8'd0);
        op8(8'd3, 8'd4, 8'd11, 0, lat);
        chk("t5_ok_latency", lat, 9);
        chk("t5_ok_product", if8.product, 8'd1);
        chk("t5_ok_err", if8.err, 0);
        bad = bad8(8'd5, 8'd5, 8'd0);
        op8(8'd5, 8'd5, 8'd0, 0, lat);
        chk("n_zero_err", if8.err, bad);
        chk("n_zero_latency", lat, bad ? 2 : 9);

        for (int i = 0; i < 1000; i++) begin
            rn = 8'($urandom_range(255, 2));
            ra = 8'($urandom_range(int'(rn) - 1, 0));
            rb = 8'($urandom_range(int'(rn) - 1, 0));
            op8(ra, rb, rn, 0, exp_lat);
            if (exp_lat != 9) chk("rand_latency", exp_lat, 9);
        end

        n256 = '0;
        n256 = n256 - 256'd189;
        a256 = 256'd1 << 255;
        op256(a256, 256'd2, n256, lat);
        chk("w256_latency", lat, 257);
        chk("w256_pow",     if256.product, 256'd189);
        op256(n256 - 256'd1, n256 - 256'd1, n256, lat);
        chk("w256_nm1",     if256.product, 256'd1);
        op256(256'd0, 256'd12345, n256, lat);
        chk("w256_zero",    if256.product, 256'd0);
        chk("w256_err",     if256.err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
